data_gen_ud: RTL and testbench

- Parametrised up/down value generator feeding the dynamic seven-segment display driver (data/point/seg_en/sign bus).
- Changes a held display value by STEP once every CNT_MAX+1 enabled clocks.
- Supports optional signed range, direction control, wrap or saturate at bounds, pause, and synchronous preload.
- Sits between the control logic and the seg_dynamic driver; outputs are register-driven.

---
 rtl/data_gen_ud_if.sv | 29 ++
 rtl/data_gen_ud.sv | 132 +++++++++++++
 tb/tb_data_gen_ud.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_gen_ud_if.sv
// Control and display bus of the up/down value generator.
// master: the generator (takes control inputs, drives the seven-segment bus).
// slave:  the controller / display side.
interface data_gen_ud_if #(
  parameter int DATA_W = 20
);
  logic              run;
  logic              dir;
  logic              wrap_mode;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_sign;
  logic [DATA_W-1:0] data;
  logic [5:0]        point;
  logic              seg_en;
  logic              sign;
  logic              tick;
  logic              at_limit;

  modport master (
    input  run, dir, wrap_mode, load, load_data, load_sign,
    output data, point, seg_en, sign, tick, at_limit
  );

  modport slave (
    output run, dir, wrap_mode, load, load_data, load_sign,
    input  data, point, seg_en, sign, tick, at_limit
  );
endinterface

// File: rtl/data_gen_ud.sv
// data_gen_ud: up/down display value generator for the dynamic seven-segment
// driver. The held value moves by STEP once every CNT_MAX+1 running clocks,
// wrapping or saturating at the range bounds; values are sign-magnitude.
// Optional macro DATA_GEN_BOUNCE_EN: a saturating bound hit reverses the
// effective count direction so the value ping-pongs between the bounds.
module data_gen_ud #(
  parameter int                CNT_W     = 23,
  parameter logic [CNT_W-1:0]  CNT_MAX   = 23'd4_999_999,
  parameter int                DATA_W    = 20,
  parameter logic [DATA_W-1:0] DATA_MAX  = 20'd999_999,
  parameter logic [DATA_W-1:0] STEP      = 20'd1,
  parameter bit                SIGNED_EN = 1'b0,
  parameter logic [5:0]        POINT     = 6'b000_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  data_gen_ud_if.master bus
);

  // Two extra bits hold the sign and the +/-2*DATA_MAX transient result.
  localparam int VW = DATA_W + 2;
  typedef logic signed [VW-1:0] val_t;

  localparam val_t UPPER  = val_t'({2'b00, DATA_MAX});
  localparam val_t LOWER  = SIGNED_EN ? -UPPER : '0;
  localparam val_t STEP_S = val_t'({2'b00, STEP});

  function automatic val_t to_val(input logic [DATA_W-1:0] mag, input logic neg);
    val_t v;
    v = val_t'({2'b00, mag});
    return neg ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] mag_of(input val_t v);
    val_t a;
    a = v[VW-1] ? -v : v;
    return DATA_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] clamp_mag(input logic [DATA_W-1:0] m);
    return (m > DATA_MAX) ? DATA_MAX : m;
  endfunction

  // Out-of-range results go to a bound exactly: the opposite one when
  // wrapping, the crossed one when saturating.
  function automatic val_t bound_fit(input val_t raw, input logic wrap);
    if (raw > UPPER) return wrap ? LOWER : UPPER;
    if (raw < LOWER) return wrap ? UPPER : LOWER;
    return raw;
  endfunction

  logic [CNT_W-1:0]  cnt_p0;
  logic              tick_p0;
  logic [DATA_W-1:0] data_p0;
  logic              sign_p0;
  logic              seg_en_p0;

  logic              eff_dir;
  logic              upd;
  val_t              cur;
  val_t              raw;
  val_t              nxt;
  logic [DATA_W-1:0] ld_mag;
  logic              ld_neg;

  assign cur    = to_val(data_p0, sign_p0);
  assign raw    = eff_dir ? (cur - STEP_S) : (cur + STEP_S);
  assign nxt    = bound_fit(raw, bus.wrap_mode);
  assign upd    = tick_p0 && bus.run;
  assign ld_mag = clamp_mag(bus.load_data);
  assign ld_neg = SIGNED_EN && bus.load_sign && (ld_mag != '0);

`ifdef DATA_GEN_BOUNCE_EN
  logic rev;
  logic cross;

  assign cross = (raw > UPPER) || (raw < LOWER);

  // Reversal flag: flips on each saturating bound hit, cleared by load.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                              rev <= 1'b0;
    else if (bus.load)                           rev <= 1'b0;
    else if (upd && !bus.wrap_mode && cross)     rev <= ~rev;
  end

  assign eff_dir = bus.dir ^ rev;
`else
  assign eff_dir = bus.dir;
`endif

  // Prescaler and tick: tick is high while cnt sits at CNT_MAX; load restarts the period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_p0  <= '0;
      tick_p0 <= 1'b0;
    end else if (bus.load) begin
      cnt_p0  <= '0;
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= bus.run && (cnt_p0 == CNT_MAX - 1'b1);
      if (bus.run) cnt_p0 <= (cnt_p0 == CNT_MAX) ? '0 : cnt_p0 + 1'b1;
    end
  end

  // Held value: load wins over an update; zero always carries a positive sign.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_p0 <= '0;
      sign_p0 <= 1'b0;
    end else if (bus.load) begin
      data_p0 <= ld_mag;
      sign_p0 <= ld_neg;
    end else if (upd) begin
      data_p0 <= mag_of(nxt);
      sign_p0 <= nxt[VW-1];
    end
  end

  // Display enable comes up on the first edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) seg_en_p0 <= 1'b0;
    else            seg_en_p0 <= 1'b1;
  end

  assign bus.data     = data_p0;
  assign bus.sign     = sign_p0;
  assign bus.tick     = tick_p0;
  assign bus.seg_en   = seg_en_p0;
  assign bus.point    = POINT;
  assign bus.at_limit = (!eff_dir && (cur == UPPER)) || (eff_dir && (cur == LOWER));

endmodule

// File: tb/tb_data_gen_ud.sv
// Bench for data_gen_ud: three instances (unsigned STEP=1, signed STEP=1,
// unsigned STEP=4) with CNT_MAX=3, DATA_MAX=9 share one set of controls.
module tb_data_gen_ud;

`ifdef DATA_GEN_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  localparam logic [5:0] PT2 = 6'b101_010;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       run   = 1'b0;
  logic       dir   = 1'b0;
  logic       wrap  = 1'b1;
  logic       load  = 1'b0;
  logic       load_sign = 1'b0;
  logic [3:0] load_data = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_gen_ud_if #(.DATA_W(4)) b0 ();
  data_gen_ud_if #(.DATA_W(4)) b1 ();
  data_gen_ud_if #(.DATA_W(4)) b2 ();

  assign b0.run = run;   assign b1.run = run;   assign b2.run = run;
  assign b0.dir = dir;   assign b1.dir = dir;   assign b2.dir = dir;
  assign b0.wrap_mode = wrap;      assign b1.wrap_mode = wrap;      assign b2.wrap_mode = wrap;
  assign b0.load = load;           assign b1.load = load;           assign b2.load = load;
  assign b0.load_data = load_data; assign b1.load_data = load_data; assign b2.load_data = load_data;
  assign b0.load_sign = load_sign; assign b1.load_sign = load_sign; assign b2.load_sign = load_sign;

  data_gen_ud #(.CNT_W(4), .CNT_MAX(4'd3), .DATA_W(4), .DATA_MAX(4'd9), .STEP(4'd1),
                .SIGNED_EN(1'b0), .POINT(6'b000_000))
    u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));
  data_gen_ud #(.CNT_W(4), .CNT_MAX(4'd3), .DATA_W(4), .DATA_MAX(4'd9), .STEP(4'd1),
                .SIGNED_EN(1'b1), .POINT(6'b000_000))
    u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));
  data_gen_ud #(.CNT_W(4), .CNT_MAX(4'd3), .DATA_W(4), .DATA_MAX(4'd9), .STEP(4'd4),
                .SIGNED_EN(1'b0), .POINT(PT2))
    u2 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b2));

  typedef struct {
    int ld; int ls; int dr; int wr;
    int l0; int l1; int l2;
    int d0; int d1; int s1; int d2;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] ld, input logic ls);
    load_data = ld;
    load_sign = ls;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ld ls dr wr  l0 l1 l2  d0 d1 s1 d2
    tbl[0]  = '{ 0, 0, 0, 1,  0, 0, 0,  1, 1, 0, 4};
    tbl[1]  = '{ 5, 1, 1, 1,  0, 0, 0,  4, 6, 1, 1};
    tbl[2]  = '{ 9, 0, 0, 1,  1, 1, 1,  0, 9, 1, 0};
    tbl[3]  = '{ 9, 0, 0, 0,  1, 1, 1,  9, 9, 0, 9};
    tbl[4]  = '{ 0, 0, 1, 1,  1, 0, 1,  9, 1, 1, 9};
    tbl[5]  = '{ 0, 0, 1, 0,  1, 0, 1,  0, 1, 1, 0};
    tbl[6]  = '{ 9, 1, 1, 1,  0, 1, 0,  8, 9, 0, 5};
    tbl[7]  = '{ 9, 1, 1, 0,  0, 1, 0,  8, 9, 1, 5};
    tbl[8]  = '{ 1, 1, 0, 1,  0, 0, 0,  2, 0, 0, 5};
    tbl[9]  = '{15, 0, 0, 1,  1, 1, 1,  0, 9, 1, 0};
    tbl[10] = '{ 8, 0, 0, 1,  0, 0, 0,  9, 9, 0, 0};
    tbl[11] = '{ 8, 0, 0, 0,  0, 0, 0,  9, 9, 0, 9};
    tbl[12] = '{ 0, 1, 0, 1,  0, 0, 0,  1, 1, 0, 4};
    tbl[13] = '{ 2, 1, 1, 0,  0, 0, 0,  1, 3, 1, 0};
    tbl[14] = '{ 3, 0, 1, 1,  0, 0, 0,  2, 2, 0, 9};

    // Reset state and free-running count from reset release.
    run = 1'b1; dir = 1'b0; wrap = 1'b1;
    step(1);
    chk("rst data0", 32'(b0.data), 0);
    chk("rst seg_en0", 32'(b0.seg_en), 0);
    chk("rst tick0", 32'(b0.tick), 0);
    chk("rst data1", 32'(b1.data), 0);
    chk("rst sign1", 32'(b1.sign), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      chk($sformatf("run%0d tick low", k), 32'(b0.tick), 0);
      if (k == 1) begin
        chk("seg_en0 up", 32'(b0.seg_en), 1);
        chk("seg_en2 up", 32'(b2.seg_en), 1);
        chk("point0", 32'(b0.point), 0);
        chk("point2", 32'(b2.point), 32'(PT2));
      end
      step(2);
      chk($sformatf("run%0d tick high", k), 32'(b0.tick), 1);
      chk($sformatf("run%0d data hold", k), 32'(b0.data), 32'((k - 1) % 10));
      step(1);
      chk($sformatf("run%0d data", k), 32'(b0.data), 32'(k % 10));
      chk($sformatf("run%0d sign0", k), 32'(b0.sign), 0);
    end
    chk("run signed data", 32'(b1.data), 8);
    chk("run signed sign", 32'(b1.sign), 1);
    chk("run step4 data", 32'(b2.data), 8);

    // Table: load, check loaded state and at_limit, then one full period.
    for (int i = 0; i < 15; i++) begin
      int lm;
      lm   = (tbl[i].ld > 9) ? 9 : tbl[i].ld;
      dir  = (tbl[i].dr != 0);
      wrap = (tbl[i].wr != 0);
      do_load(4'(tbl[i].ld), tbl[i].ls != 0);
      chk($sformatf("row%0d ld d0", i), 32'(b0.data), lm);
      chk($sformatf("row%0d ld s0", i), 32'(b0.sign), 0);
      chk($sformatf("row%0d ld d1", i), 32'(b1.data), lm);
      chk($sformatf("row%0d ld s1", i), 32'(b1.sign), 32'((tbl[i].ls != 0) && (lm != 0)));
      chk($sformatf("row%0d ld d2", i), 32'(b2.data), lm);
      chk($sformatf("row%0d lim0", i), 32'(b0.at_limit), tbl[i].l0);
      chk($sformatf("row%0d lim1", i), 32'(b1.at_limit), tbl[i].l1);
      chk($sformatf("row%0d lim2", i), 32'(b2.at_limit), tbl[i].l2);
      chk($sformatf("row%0d ld tick", i), 32'(b0.tick), 0);
      step(3);
      chk($sformatf("row%0d tick", i), 32'(b0.tick), 1);
      step(1);
      chk($sformatf("row%0d d0", i), 32'(b0.data), tbl[i].d0);
      chk($sformatf("row%0d d1", i), 32'(b1.data), tbl[i].d1);
      chk($sformatf("row%0d s1", i), 32'(b1.sign), tbl[i].s1);
      chk($sformatf("row%0d d2", i), 32'(b2.data), tbl[i].d2);
    end

    // Signed range counting down from 0 through -9, wrap to +9, then -1 up to 0.
    dir = 1'b1; wrap = 1'b1;
    do_load(4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(4);
      chk($sformatf("down%0d d1", k), 32'(b1.data), (k <= 9) ? k : 9);
      chk($sformatf("down%0d s1", k), 32'(b1.sign), (k <= 9) ? 1 : 0);
      if (k == 9) chk("down lim1", 32'(b1.at_limit), 1);
    end
    dir = 1'b0;
    do_load(4'd1, 1'b1);
    chk("m1 d1", 32'(b1.data), 1);
    chk("m1 s1", 32'(b1.sign), 1);
    step(4);
    chk("zero d1", 32'(b1.data), 0);
    chk("zero s1", 32'(b1.sign), 0);
    step(4);
    chk("p1 d1", 32'(b1.data), 1);
    chk("p1 s1", 32'(b1.sign), 0);

    // Saturate at the upper bound (or bounce off it).
    dir = 1'b0; wrap = 1'b0;
    do_load(4'd9, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(3);
      chk($sformatf("sat%0d tick", k), 32'(b0.tick), 1);
      step(1);
      chk($sformatf("sat%0d d0", k), 32'(b0.data), BOUNCE ? 10 - k : 9);
      chk($sformatf("sat%0d lim0", k), 32'(b0.at_limit), BOUNCE ? 0 : 1);
    end

    // Load landing in the tick cycle wins and restarts the period.
    dir = 1'b0; wrap = 1'b1;
    do_load(4'd2, 1'b0);
    step(3);
    chk("ldtick tick", 32'(b0.tick), 1);
    load_data = 4'd15; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("ldtick d0", 32'(b0.data), 9);
    chk("ldtick tick clr", 32'(b0.tick), 0);
    step(2);
    chk("ldtick tick2 low", 32'(b0.tick), 0);
    step(1);
    chk("ldtick tick2 high", 32'(b0.tick), 1);
    chk("ldtick d0 hold", 32'(b0.data), 9);
    step(1);
    chk("ldtick d0 wrap", 32'(b0.data), 0);

    // run=0 freezes the prescaler mid-period.
    do_load(4'd4, 1'b0);
    step(2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk($sformatf("frz%0d tick", k), 32'(b0.tick), 0);
      chk($sformatf("frz%0d d0", k), 32'(b0.data), 4);
    end
    run = 1'b1;
    step(1);
    chk("resume tick", 32'(b0.tick), 1);
    step(1);
    chk("resume d0", 32'(b0.data), 5);
    chk("resume tick low", 32'(b0.tick), 0);

    // run falling in the tick cycle skips that update.
    step(3);
    chk("skip tick", 32'(b0.tick), 1);
    run = 1'b0;
    step(1);
    chk("skip d0", 32'(b0.data), 5);
    chk("skip tick low", 32'(b0.tick), 0);
    run = 1'b1;
    step(1);
    chk("skip wrap tick", 32'(b0.tick), 0);
    chk("skip wrap d0", 32'(b0.data), 5);
    step(3);
    chk("next tick", 32'(b0.tick), 1);
    step(1);
    chk("next d0", 32'(b0.data), 6);

    // Asynchronous reset mid-period, no clock edge in between.
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst d0", 32'(b0.data), 0);
    chk("arst seg_en0", 32'(b0.seg_en), 0);
    chk("arst tick0", 32'(b0.tick), 0);
    chk("arst d1", 32'(b1.data), 0);
    chk("arst s1", 32'(b1.sign), 0);
    chk("arst d2", 32'(b2.data), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rerelease seg_en0", 32'(b0.seg_en), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
